// File: rtl/debugger_uart_rx.sv
// Oversampling 8N1 UART receiver feeding the MIPS debug unit's command decoder.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module debugger_uart_rx #(
    parameter int unsigned BAUD_DIV   = 27,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] code,
    output logic                 code_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned S_W   = $clog2(OVERSAMPLE);
    localparam int unsigned N_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 rx_meta_q, rx_s_q;
    logic [S_W-1:0]       s_q, s_d;
    logic [N_W-1:0]       n_q, n_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] code_q, code_d;
    logic                 code_valid_q, code_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 tick;
    logic                 bit_end;
`ifdef UART_RX_PARITY_EN
    logic                 par_err_q, par_err_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            s_q          <= '0;
            n_q          <= '0;
            shreg_q      <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            s_q          <= s_d;
            n_q          <= n_d;
            shreg_q      <= shreg_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    // Free-running divider: the FSM only ever observes tick, never resets the phase.
    always_comb begin
        tick    = (div_q == DIV_W'(BAUD_DIV - 1));
        div_d   = tick ? '0 : div_q + 1'b1;
        bit_end = (s_q == S_W'(OVERSAMPLE - 1));
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        shreg_d      = shreg_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d    = par_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_W'(OVERSAMPLE / 2 - 1)) begin
                        state_d = rx_s_q ? IDLE : DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_end) begin
                        shreg_d = {rx_s_q, shreg_q} >> 1;
                        s_d     = '0;
                        if (n_q == N_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (bit_end) begin
                        par_err_d = ^{shreg_q, rx_s_q};
                        s_d       = '0;
                        state_d   = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (bit_end) begin
                        s_d = '0;
                        if (rx_s_q) begin
                            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_err_q) begin
                                frame_err_d = 1'b1;
                            end else begin
                                code_d       = shreg_q;
                                code_valid_d = 1'b1;
                            end
`else
                            code_d       = shreg_q;
                            code_valid_d = 1'b1;
`endif
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_debugger_uart_rx.sv
// Directed bench for debugger_uart_rx at BAUD_DIV=2, OVERSAMPLE=16 (32 clk per bit).
// Define UART_RX_PARITY_EN for both RTL and bench to exercise 8E1 frames.
module tb_debugger_uart_rx;

    localparam int BIT_CLK = 32;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int LAT_NOM = BIT_CLK * (8 + PBITS + 1) + BIT_CLK / 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int first_cv_cyc = 0;
    int last_drive_cyc = 0;
    int start_cyc = 0;
    logic [7:0] codes[$];

    debugger_uart_rx #(
        .BAUD_DIV  (2),
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .code      (code),
        .code_valid(code_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (code_valid) begin
                if (cv_cnt == 0) first_cv_cyc = cyc;
                cv_cnt++;
                codes.push_back(code);
            end
            if (frame_err) fe_cnt++;
            if (code_valid && frame_err) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        cv_cnt = 0;
        fe_cnt = 0;
        codes.delete();
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk);
        rx = v;
        last_drive_cyc = cyc;
        repeat (BIT_CLK - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par);
        drive_bit(1'b0);
        start_cyc = last_drive_cyc;
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ bad_par);
`endif
        drive_bit(stop);
    endtask

    int lat;

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_code", code, 8'h00);
        check("rst_code_valid", code_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        repeat (20) @(negedge clk);

        // 1: single frame
        clr();
        send_frame(8'h3F, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("t1_pulses", cv_cnt, 1);
        check("t1_code", code, 8'h3F);
        check("t1_frame_err", fe_cnt, 0);
        check("t1_busy", busy, 1'b0);
        lat = first_cv_cyc - start_cyc;
        check("t1_latency_window", (lat >= LAT_NOM - 4) && (lat <= LAT_NOM + 8), 1'b1);

        // 2: back-to-back frames
        clr();
        send_frame(8'h3F, 1'b1, 1'b0);
        send_frame(8'h38, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("t2_pulses", cv_cnt, 2);
        check("t2_code0", (codes.size() > 0) ? codes[0] : 8'hXX, 8'h3F);
        check("t2_code1", (codes.size() > 1) ? codes[1] : 8'hXX, 8'h38);
        check("t2_frame_err", fe_cnt, 0);

        // 3: short glitch rejected
        clr();
        @(negedge clk);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        check("t3_busy_during", busy, 1'b1);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        check("t3_pulses", cv_cnt, 0);
        check("t3_frame_err", fe_cnt, 0);
        check("t3_idle", busy, 1'b0);

        // 4: bad stop bit, line held low
        clr();
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check("t4_break_busy", busy, 1'b1);
        check("t4_frame_err", fe_cnt, 1);
        check("t4_pulses", cv_cnt, 0);
        check("t4_code_kept", code, 8'h38);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_idle", busy, 1'b0);
        check("t4_frame_err_once", fe_cnt, 1);
        check("t4_no_new_frame", cv_cnt, 0);

        // 5: reset mid data bit 4
        clr();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(a5[i]);
        @(negedge clk);
        rx = a5[4];
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_code", code, 8'h00);
        check("t5_code_valid", code_valid, 1'b0);
        check("t5_frame_err", frame_err, 1'b0);
        check("t5_busy", busy, 1'b0);
        reset = 1'b0;
        rx = 1'b1;
        repeat (40) @(negedge clk);
        clr();
        send_frame(8'h38, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("t5_pulses", cv_cnt, 1);
        check("t5_code_after", code, 8'h38);
        check("t5_fe_after", fe_cnt, 0);

`ifdef UART_RX_PARITY_EN
        // 6: parity good then bad
        clr();
        send_frame(8'h3F, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        clr();
        send_frame(8'h38, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("t6_good_pulses", cv_cnt, 1);
        check("t6_good_code", code, 8'h38);
        check("t6_good_fe", fe_cnt, 0);
        clr();
        send_frame(8'h3F, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("t6_bad_pulses", cv_cnt, 0);
        check("t6_bad_fe", fe_cnt, 1);
        check("t6_bad_code_kept", code, 8'h38);
        check("t6_bad_idle", busy, 1'b0);
`endif

        check("no_dual_strobe", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
